spi_sched: RTL and testbench

Round-robin scheduler and sequencer for the dual-lane SPI port. It shares one two-lane shift engine between NREQ requesters, each owning one chip-select. It captures the granted requester's word, drives O_sck/O_mosi, samples I_miso, and returns the received word with a one-cycle acknowledge. It sits between the core-side clients and the O_mosi/I_miso/O_sck pins of top.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_shifter.sv | 95 +++++++++
 rtl/spi_sched.sv | 114 +++++++++++
 tb/tb_spi_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the dual-lane SPI scheduler: sequencer states and lane count.
package spi_pkg;

    localparam int LANES = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        ACK
    } state_e;

endpackage

// File: rtl/spi_shifter.sv
// Dual-lane mode-0 shift engine: half-period and bit-pair counters, SCK generation,
// MSB-first transmit/receive registers and an end-of-shift done pulse.
module spi_shifter
    import spi_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CLKDIV = 2
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_load,
    input  logic [WIDTH-1:0]   I_wdata,
    input  logic               I_setup,
    input  logic               I_shift,
    input  logic               I_active,
    input  logic [0:LANES-1]   I_miso,
    output logic               O_half_done,
    output logic               O_done,
    output logic [0:LANES-1]   O_sck,
    output logic [0:LANES-1]   O_mosi,
    output logic [WIDTH-1:0]   O_rx
);

    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int PW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;

    logic [CW-1:0]    hcnt_q, hcnt_d;
    logic [PW-1:0]    pair_q, pair_d;
    logic             phase_q, phase_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;

    logic half_done, last_pair, rise, fall;

    // phase_q = 0 is the high half of an SCK period, 1 the low half.
    assign half_done = I_active && (hcnt_q == CW'(CLKDIV - 1));
    assign last_pair = (pair_q == PW'(WIDTH / 2 - 1));
    // SCK rises at the end of SETUP and at the end of every low half except the last.
    assign rise      = half_done && (I_setup || (I_shift && phase_q && !last_pair));
    assign fall      = I_shift && half_done && !phase_q;

    always_comb begin
        hcnt_d  = hcnt_q;
        phase_d = phase_q;
        pair_d  = pair_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        if (I_load) begin
            hcnt_d  = '0;
            phase_d = 1'b0;
            pair_d  = '0;
            tx_d    = I_wdata;
            rx_d    = '0;
        end else begin
            if (I_active) begin
                hcnt_d = half_done ? '0 : hcnt_q + 1'b1;
            end
            if (I_shift && half_done) begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    pair_d = last_pair ? '0 : pair_q + 1'b1;
                end
            end
            if (rise) begin
                rx_d = WIDTH'({rx_q, I_miso[0], I_miso[1]});
            end
            if (fall) begin
                tx_d = WIDTH'({tx_q, 2'b00});
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            hcnt_q  <= '0;
            phase_q <= 1'b0;
            pair_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            hcnt_q  <= hcnt_d;
            phase_q <= phase_d;
            pair_q  <= pair_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end

    assign O_half_done = half_done;
    assign O_done      = I_shift && half_done && phase_q && last_pair;
    assign O_sck       = {LANES{I_shift && !phase_q}};
    assign O_mosi      = I_active ? {tx_q[WIDTH-1], tx_q[WIDTH-2]} : '0;
    assign O_rx        = rx_q;

endmodule

// File: rtl/spi_sched.sv
// Round-robin arbiter and transfer sequencer sharing one dual-lane SPI shift engine
// between NREQ requesters, each owning one chip-select.
module spi_sched
    import spi_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int WIDTH  = 8,
    parameter int CLKDIV = 2
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic [NREQ-1:0]       I_req,
    input  logic [NREQ*WIDTH-1:0] I_wdata,
    output logic [NREQ-1:0]       O_ack,
    output logic [WIDTH-1:0]      O_rdata,
    output logic                  O_busy,
    output logic [NREQ-1:0]       O_cs_n,
    output logic [0:LANES-1]      O_mosi,
    input  logic [0:LANES-1]      I_miso,
    output logic [0:LANES-1]      O_sck,
    output state_e                O_state
);

    localparam int GW = $clog2(NREQ);

    // Handshake: I_req[i] is a level; a request seen in IDLE is granted, its word captured,
    // and exactly one O_ack[i] pulse ends it. Dropping I_req mid-transfer never aborts.
    state_e           state_q, state_d;
    logic [GW-1:0]    last_q, last_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [GW-1:0]    win;
    logic             load, half_done, shift_done, active;
    logic [WIDTH-1:0] rx;

    always_comb begin
        win = last_q;
        for (int i = NREQ; i >= 1; i--) begin
            if (I_req[(int'(last_q) + i) % NREQ]) begin
                win = GW'((int'(last_q) + i) % NREQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        rdata_d = rdata_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|I_req) begin
                    last_d  = win;
                    load    = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: if (half_done) state_d = SHIFT;
            SHIFT: if (shift_done) state_d = HOLD;
            HOLD: begin
                if (half_done) begin
                    rdata_d = rx;
                    state_d = ACK;
                end
            end
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            state_q <= IDLE;
            last_q  <= GW'(NREQ - 1);
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end

    assign active = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);

    always_comb begin
        O_cs_n = '1;
        O_ack  = '0;
        if (active) O_cs_n[last_q] = 1'b0;
        if (state_q == ACK) O_ack[last_q] = 1'b1;
    end

    spi_shifter #(
        .WIDTH (WIDTH),
        .CLKDIV(CLKDIV)
    ) u_shifter (
        .I_clk      (I_clk),
        .I_rst      (I_rst),
        .I_load     (load),
        .I_wdata    (I_wdata[int'(win)*WIDTH +: WIDTH]),
        .I_setup    (state_q == SETUP),
        .I_shift    (state_q == SHIFT),
        .I_active   (active),
        .I_miso     (I_miso),
        .O_half_done(half_done),
        .O_done     (shift_done),
        .O_sck      (O_sck),
        .O_mosi     (O_mosi),
        .O_rx       (rx)
    );

    assign O_rdata = rdata_q;
    assign O_busy  = (state_q != IDLE);
    assign O_state = state_q;

endmodule

// File: tb/tb_spi_sched.sv
// Directed bench for spi_sched: driver pushes expected {ack, rdata} into a queue,
// a negedge monitor pops and compares on every ack pulse.
module tb_spi_sched;
  import spi_pkg::*;

  localparam int NREQ   = 2;
  localparam int WIDTH  = 8;
  localparam int CLKDIV = 2;
  localparam int EW     = NREQ + WIDTH;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      rdata;
  logic                  busy;
  logic [NREQ-1:0]       cs_n;
  logic [0:1]            mosi;
  logic [0:1]            miso;
  logic [0:1]            sck;
  logic [0:1]            miso_fix;
  logic                  loop_en;
  state_e                dbg_state;

  assign miso = loop_en ? mosi : miso_fix;

  spi_sched #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .CLKDIV(CLKDIV)
  ) dut (
    .I_clk  (clk),
    .I_rst  (rst_n),
    .I_req  (req),
    .I_wdata(wdata),
    .O_ack  (ack),
    .O_rdata(rdata),
    .O_busy (busy),
    .O_cs_n (cs_n),
    .O_mosi (mosi),
    .I_miso (miso),
    .O_sck  (sck),
    .O_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int ack_seen = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic          prev_sck_hi = 1'b0;
  logic [0:1]    prev_mosi = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending acks expected 0", exp_q.size());
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && ack != '0) begin
      ack_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got ack=%b rdata=%h expected no ack", ack, rdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_vec", 32'(ack), 32'(mon_e[EW-1:WIDTH]));
        check("ack_rdata", 32'(rdata), 32'(mon_e[WIDTH-1:0]));
        check("ack_cs_released", 32'(cs_n), 32'({NREQ{1'b1}}));
        check("ack_busy", 32'(busy), 32'd1);
      end
    end
  end

  // pin-level invariants
  always @(negedge clk) begin
    if (rst_n) begin
      check("sck_lanes_equal", 32'(sck[0]), 32'(sck[1]));
      check("cs_at_most_one", 32'($countones(~cs_n) <= 1), 32'd1);
      if (prev_sck_hi && sck[0]) check("mosi_stable_sck_high", 32'(mosi), 32'(prev_mosi));
    end
    prev_sck_hi = sck[0];
    prev_mosi   = mosi;
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cs_n"}, 32'(cs_n), 32'(2'b11));
    check({tag, "_sck"}, 32'(sck), 32'(2'b00));
    check({tag, "_mosi"}, 32'(mosi), 32'(2'b00));
    check({tag, "_ack"}, 32'(ack), 32'(2'b00));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'h00);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  int n_ack;
  int gap;
  logic [3:0] lane0, lane1;
  logic prev_hi;

  initial begin
    req = '0;
    wdata = '0;
    loop_en = 1'b1;
    miso_fix = 2'b00;
    rst_n = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // single transfer, loopback, latency and lane bit order
    wdata = {8'h00, 8'hA5};
    exp_q.push_back({2'b01, 8'hA5});
    req = 2'b01;
    n_ack = 0;
    lane0 = '0;
    lane1 = '0;
    prev_hi = 1'b0;
    for (int n = 1; n <= 40 && n_ack == 0; n++) begin
      tick();
      if (n == 1) begin
        req = 2'b00;
        wdata = {8'h00, 8'h00};
      end
      if (sck == 2'b11 && !prev_hi) begin
        lane0 = {lane0[2:0], mosi[0]};
        lane1 = {lane1[2:0], mosi[1]};
      end
      prev_hi = sck[0];
      if (ack != '0) n_ack = n;
    end
    check("latency", 32'(n_ack), 32'd21);
    check("lane0_bits", 32'(lane0), 32'(4'b1100));
    check("lane1_bits", 32'(lane1), 32'(4'b0011));
    repeat (3) tick();
    check("rdata_held", 32'(rdata), 32'hA5);
    check("busy_after", 32'(busy), 32'd0);

    // fixed MISO pattern on requester 1
    loop_en = 1'b0;
    miso_fix = 2'b10;
    wdata = {8'h0F, 8'h00};
    exp_q.push_back({2'b10, 8'hAA});
    req = 2'b10;
    tick();
    req = 2'b00;
    drain(60);
    loop_en = 1'b1;

    // simultaneous requests straight out of reset, back-to-back grant spacing
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    wdata = {8'h34, 8'h12};
    exp_q.push_back({2'b01, 8'h12});
    exp_q.push_back({2'b10, 8'h34});
    req = 2'b11;
    for (int i = 0; i < 10 && cs_n == 2'b11; i++) tick();
    check("cs_first", 32'(cs_n), 32'(2'b10));
    for (int i = 0; i < 40 && ack == '0; i++) tick();
    check("first_ack_seen", 32'(ack), 32'(2'b01));
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      gap++;
      if (cs_n != 2'b11) break;
    end
    check("b2b_gap", 32'(gap), 32'd2);
    check("cs_second", 32'(cs_n), 32'(2'b01));
    req = 2'b00;
    drain(60);

    // fairness with both requests held
    wdata = {8'h5A, 8'hC3};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'b01, 8'hC3});
      exp_q.push_back({2'b10, 8'h5A});
    end
    n_ack = ack_seen + 6;
    req = 2'b11;
    for (int i = 0; i < 200 && ack_seen < n_ack; i++) tick();
    req = 2'b00;
    drain(60);

    // reset asserted mid-SHIFT, then a clean transfer
    wdata = {8'h00, 8'hFF};
    req = 2'b01;
    repeat (8) tick();
    check("mid_shift_state", 32'(dbg_state), 32'(SHIFT));
    #2;
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    check_idle_outputs("async_reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    wdata = {8'h3C, 8'h00};
    exp_q.push_back({2'b10, 8'h3C});
    req = 2'b10;
    tick();
    req = 2'b00;
    drain(60);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
